// File: rtl/ram_clr.sv
// rtl/ram_clr.sv - single-port RAM with combinational read and a zero-sweep sequencer.
// The array itself has no reset; it is zeroed by the sweep that follows reset release or a clear request.
module ram_clr #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_last;

  assign w_last = (r_clr_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      S_CLEAR: begin
        // Counter parks at zero on exit so it never runs past the last word.
        if (w_last) begin
          w_state_nxt    = S_IDLE;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + 1'b1;
        end
      end
      default: begin
        if (clear) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
    endcase
  end

  // User writes are only accepted while idle; the sweep owns the port otherwise.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_addr] <= '0;
    end else if (load) begin
      r_mem[address] <= in;
    end
  end

  assign busy = (r_state == S_CLEAR);
  assign out  = busy ? '0 : r_mem[address];

endmodule

// File: doc/ram_clr.md
# ram_clr

Parametrised single-port RAM with the same address/in/load/out contract as the fixed-size RAM blocks. It adds a built-in clear sequencer that sweeps every word to zero after reset and on request, and exposes a `busy` flag while the sweep runs. It is the memory used wherever a known-zero start state is required: data memory for the CPU and scratch buffers.

## Interface
- `WIDTH`, default 16: data word width in bits.
- `ADDR_W`, default 12: address width; `DEPTH` = 2**`ADDR_W` words (4096 by default).
- `clk`  input  1: single clock; all state changes happen on the rising edge except reset.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `address`  input  `ADDR_W`: word address for read and write.
- `in`  input  `WIDTH`: write data.
- `load`  input  1: write enable, sampled on the rising edge of `clk`.
- `clear`  input  1: request a full zero sweep, sampled on the rising edge.
- `out`  output  `WIDTH`: read data for the current `address`.
- `busy`  output  1: high while the clear sweep is in progress.

## Operation
- Storage is `DEPTH` words of `WIDTH` bits.
- The reset does not touch the array. The array is zeroed by the sweep that starts when reset is released.
- The sequencer has two states, IDLE and CLEAR, and one internal counter `clr_addr` (`ADDR_W` bits).
- While `rst_n` = 0:
  - the state is CLEAR;
  - `clr_addr` = 0;
  - `busy` = 1;
  - `out` = 0.
- In the CLEAR state, on each rising edge:
  - write 0 to `mem[clr_addr]`;
  - if `clr_addr` = `DEPTH`-1, go to IDLE and set `busy` to 0;
  - otherwise increment `clr_addr`.
- During CLEAR:
  - `load` is ignored and no user write occurs;
  - `clear` is ignored, so the sweep does not restart;
  - `out` is forced to 0.
- In the IDLE state, on each rising edge:
  - if `load` = 1, write `in` to `mem[address]`;
  - if `clear` = 1, go to CLEAR, set `clr_addr` to 0 and set `busy` to 1.
  - If `load` and `clear` are both 1 on the same edge, both actions occur. The written word is later zeroed by the sweep.
- In IDLE, `out` is a combinational read of `mem[address]` and follows `address` with no clock delay.
- Width rules:
  - `address` is used in full and has no out-of-range values;
  - `clr_addr` wraps only through the transition to IDLE and never increments past `DEPTH`-1.
- Reset asserted in the middle of a sweep aborts it. On release, the sweep restarts from address 0.

## Timing
- Write latency: 1 edge. After the edge with `load` = 1, `out` shows the new data if `address` is unchanged.
- Read latency: 0 cycles in IDLE.
- Sweep after reset release: `busy` stays 1 for exactly `DEPTH` rising edges and falls after the `DEPTH`-th edge.
- Requested sweep: `clear` is sampled at edge k.
  - `busy` rises after edge k.
  - Edges k+1 through k+`DEPTH` perform the zero writes.
  - `busy` falls after edge k+`DEPTH`.
- `busy` is a registered output, apart from its asynchronous assertion on reset.
- Reset values of the outputs: `busy` = 1 and `out` = 0.

## Test plan
- Reset release sweep with `ADDR_W`=3 (`DEPTH` = 8):
  - Stimulus: release `rst_n` and count edges.
  - Required response: `busy` stays 1 for 8 edges, then 0. After that, every address reads 0.
- Write/read with the default parameters:
  - Stimulus: after the sweep, write 0xA5A5 to address 0, 0x1234 to address 3, 0x00FF to address 7 and 0xFFFF to address 4095.
  - Required response: each address reads back its value one edge after the write. Address 1 still reads 0.
- Load with load=0:
  - Stimulus: `load` = 0 with `in` = 0xBEEF at address 4095.
  - Required response: the previous value 0xFFFF is retained.
- Clear request with `ADDR_W`=3:
  - Stimulus: fill all 8 words with nonzero data, then pulse `clear` for one edge.
  - Required response: `busy` is 1 for exactly 8 edges and `out` is 0 throughout. Afterwards all words read 0.
- Load during sweep:
  - Stimulus: while `busy` = 1, assert `load` with `in` = 0x7777 at address 2, and re-pulse `clear`.
  - Required response: address 2 reads 0 after the sweep, and the sweep length is unchanged at 8 edges.
- Reset mid-sweep:
  - Stimulus: pull `rst_n` low after 4 sweep edges, then release it.
  - Required response: `busy` rises immediately, and 8 full edges follow the release before `busy` falls.
